// File: rtl/fir_sched_pkg.sv
// Shared types and default frame geometry for the FIR frame scheduler.
package fir_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        FEED,
        DRAIN,
        DONE
    } state_t;

    localparam int DEF_N_SAMPLES = 32;
    localparam int DEF_FLUSH_LEN = 8;
    localparam int DEF_LATENCY   = 8;

endpackage

// File: rtl/fir_tag_pipe.sv
// Fixed-depth shift register of a single valid bit with synchronous clear;
// tracks which filter outputs correspond to real frame samples.
module fir_tag_pipe #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] pipe_q;
    logic [DEPTH-1:0] pipe_d;

    generate
        if (DEPTH == 1) begin : g_one
            always_comb pipe_d = clr_i ? 1'b0 : d_i;
        end else begin : g_multi
            always_comb pipe_d = clr_i ? '0 : {pipe_q[DEPTH-2:0], d_i};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe_q <= '0;
        else        pipe_q <= pipe_d;
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/fir_frame_sched.sv
// Sequences one frame through the shared FIR datapath: zero flush, X feed,
// then Y capture once the filter latency has elapsed.
module fir_frame_sched
    import fir_sched_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 5,
    parameter int N_SAMPLES = DEF_N_SAMPLES,
    parameter int FLUSH_LEN = DEF_FLUSH_LEN,
    parameter int LATENCY   = DEF_LATENCY
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          start_i,
    input  logic          abort_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          valid_o,
    output logic          aborted_o,
    output logic          err_o,
    output logic          x_rd_en_o,
    output logic [AW-1:0] x_rd_addr_o,
    input  logic [DW-1:0] x_rd_data_i,
    output logic [DW-1:0] fir_in_o,
    input  logic [DW-1:0] fir_out_i,
    output logic          y_wr_en_o,
    output logic [AW-1:0] y_wr_addr_o,
    output logic [DW-1:0] y_wr_data_o
);

    localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
    localparam logic [FW-1:0] FL_LAST = FW'(FLUSH_LEN - 1);
    localparam logic [AW-1:0] S_LAST  = AW'(N_SAMPLES - 1);

    state_t        state_q, state_d;
    logic [FW-1:0] fl_cnt_q, fl_cnt_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic          fv_q, fv_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          aborted_q, aborted_d;
    logic          tag_clr;
    logic          tag_out;
    logic          busy;

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        fl_cnt_d  = fl_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        fv_d      = 1'b0;
        valid_d   = valid_q;
        err_d     = err_q;
        aborted_d = 1'b0;
        tag_clr   = 1'b0;

        if (busy && start_i) err_d = 1'b1;

        if (busy && abort_i) begin
            // In-flight tags are dropped so no stale Y write follows an abort.
            state_d   = IDLE;
            fl_cnt_d  = '0;
            rd_cnt_d  = '0;
            wr_cnt_d  = '0;
            valid_d   = 1'b0;
            aborted_d = 1'b1;
            tag_clr   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i && !abort_i) begin
                        state_d  = FLUSH;
                        fl_cnt_d = '0;
                        rd_cnt_d = '0;
                        wr_cnt_d = '0;
                        valid_d  = 1'b0;
                        err_d    = 1'b0;
                        tag_clr  = 1'b1;
                    end
                end
                FLUSH: begin
                    if (fl_cnt_q == FL_LAST) state_d = FEED;
                    else                     fl_cnt_d = fl_cnt_q + FW'(1);
                end
                FEED: begin
                    fv_d = 1'b1;
                    if (rd_cnt_q == S_LAST) state_d = DRAIN;
                    else                    rd_cnt_d = rd_cnt_q + AW'(1);
                end
                DRAIN: begin
                    if (tag_out && wr_cnt_q == S_LAST) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase

            // Write address saturates on the last sample rather than wrapping.
            if (tag_out && wr_cnt_q != S_LAST) wr_cnt_d = wr_cnt_q + AW'(1);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= IDLE;
            fl_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            fv_q      <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fl_cnt_q  <= fl_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            fv_q      <= fv_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            aborted_q <= aborted_d;
        end
    end

    fir_tag_pipe #(
        .DEPTH (LATENCY)
    ) u_tag_pipe (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .clr_i (tag_clr),
        .d_i   (fv_q),
        .q_o   (tag_out)
    );

    // fv_q lines up with the RAM's one-cycle read latency.
    assign fir_in_o    = fv_q ? x_rd_data_i : '0;
    assign x_rd_en_o   = (state_q == FEED);
    assign x_rd_addr_o = x_rd_en_o ? rd_cnt_q : '0;
    assign y_wr_en_o   = tag_out;
    assign y_wr_addr_o = tag_out ? wr_cnt_q : '0;
    assign y_wr_data_o = tag_out ? fir_out_i : '0;

    assign busy_o    = busy;
    assign done_o    = (state_q == DONE);
    assign valid_o   = valid_q;
    assign aborted_o = aborted_q;
    assign err_o     = err_q;

endmodule
